// File: rtl/vga_fill_pkg.sv
// Shared types and constants for the command-driven VGA plot engine.
package vga_fill_pkg;

  // Register word addresses
  localparam logic [3:0] ADDR_PLOT    = 4'd0;
  localparam logic [3:0] ADDR_XY0     = 4'd1;
  localparam logic [3:0] ADDR_XY1_GO  = 4'd2;
  localparam logic [3:0] ADDR_CLEAR   = 4'd3;
  localparam logic [3:0] ADDR_STATUS  = 4'd4;
  localparam logic [3:0] ADDR_ERR_CLR = 4'd5;

  // STATUS bit positions
  localparam int unsigned ST_BUSY_BIT  = 0;
  localparam int unsigned ST_FULL_BIT  = 1;
  localparam int unsigned ST_ERR_BIT   = 2;
  localparam int unsigned ST_COUNT_LSB = 8;

  // Widest colour the engine supports; narrower colours use the LSBs
  localparam int unsigned COLOUR_MAX_W = 16;

  typedef enum logic [0:0] {StIdle, StDraw} state_e;

  typedef struct packed {
    logic [7:0]              x0;
    logic [7:0]              y0;
    logic [7:0]              x1;
    logic [7:0]              y1;
    logic [COLOUR_MAX_W-1:0] colour;
  } cmd_t;

  function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? b : a;
  endfunction

endpackage

// File: rtl/vga_avalon_fill_if.sv
// Avalon-MM slave bus plus pixel plot stream of the fill engine.
interface vga_avalon_fill_if #(
  parameter int unsigned COLOUR_W = 8
);
  logic [3:0]          address;
  logic                read;
  logic [31:0]         readdata;
  logic                write;
  logic [31:0]         writedata;
  logic                waitrequest;
  logic [7:0]          pix_x;
  logic [7:0]          pix_y;
  logic [COLOUR_W-1:0] pix_colour;
  logic                pix_plot;
  logic                pix_ready;

  modport slave (
    input  address, read, write, writedata, pix_ready,
    output readdata, waitrequest, pix_x, pix_y, pix_colour, pix_plot
  );

  modport master (
    output address, read, write, writedata, pix_ready,
    input  readdata, waitrequest, pix_x, pix_y, pix_colour, pix_plot
  );
endinterface

// File: rtl/vga_cmd_fifo.sv
// Small synchronous FIFO for queued draw commands; read data is show-ahead.
module vga_cmd_fifo #(
  parameter int unsigned Width = 48,
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointer and occupancy update; pointers wrap naturally (Depth is a power of two)
  always_comb begin
    wr_ptr_d = wr_ptr_q + PtrW'(do_push);
    rd_ptr_d = rd_ptr_q + PtrW'(do_pop);
    count_d  = count_q + CntW'(do_push) - CntW'(do_pop);
  end

  // Pointer/count state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/vga_avalon_fill.sv
// Avalon-MM command front end and raster plot engine for the VGA framebuffer.
module vga_avalon_fill
  import vga_fill_pkg::*;
#(
  parameter int unsigned H_RES      = 160,
  parameter int unsigned V_RES      = 120,
  parameter int unsigned COLOUR_W   = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input logic              clk,
  input logic              reset,
  vga_avalon_fill_if.slave bus
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]              wx, wy;
  logic [COLOUR_MAX_W-1:0] wcol;
  logic                    in_range, is_cmd_addr, wr_acc;
  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CntW-1:0]         fifo_count;
  cmd_t                    push_cmd, fifo_rdata;
  logic [7:0]              sx_q, sx_d, sy_q, sy_d;
  logic                    err_q, err_d, err_set, err_clr;
  state_e                  state_q, state_d;
  logic [7:0]              cx_q, cx_d, cy_q, cy_d;
  logic [7:0]              x0_q, x0_d, x1_q, x1_d, y1_q, y1_d;
  logic [COLOUR_W-1:0]     col_q, col_d;
  logic                    busy;
  logic                    unused_sig;

  assign wx          = bus.writedata[23:16];
  assign wy          = bus.writedata[31:24];
  assign wcol        = COLOUR_MAX_W'(bus.writedata[COLOUR_W-1:0]);
  assign in_range    = ({1'b0, wx} < 9'(H_RES)) && ({1'b0, wy} < 9'(V_RES));
  assign is_cmd_addr = (bus.address == ADDR_PLOT) || (bus.address == ADDR_XY1_GO) ||
                       (bus.address == ADDR_CLEAR);
  // Stall is purely the current full flag; a same-cycle pop does not help
  assign bus.waitrequest = bus.write & is_cmd_addr & fifo_full;
  assign wr_acc          = bus.write & ~bus.waitrequest;
  assign busy            = (state_q == StDraw) | ~fifo_empty;
  assign unused_sig      = ^{bus.writedata[15:0], fifo_rdata.colour};

  vga_cmd_fifo #(
    .Width($bits(cmd_t)),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (fifo_push),
    .wdata_i(push_cmd),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  // Register write decode, range check and corner normalisation
  always_comb begin
    fifo_push = 1'b0;
    push_cmd  = '0;
    sx_d      = sx_q;
    sy_d      = sy_q;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    if (wr_acc) begin
      case (bus.address)
        ADDR_PLOT: begin
          if (in_range) begin
            fifo_push = 1'b1;
            push_cmd  = '{x0: wx, y0: wy, x1: wx, y1: wy, colour: wcol};
          end else begin
            err_set = 1'b1;
          end
        end
        ADDR_XY0: begin
          if (in_range) begin
            sx_d = wx;
            sy_d = wy;
          end else begin
            err_set = 1'b1;
          end
        end
        ADDR_XY1_GO: begin
          if (in_range) begin
            fifo_push = 1'b1;
            push_cmd  = '{x0: min8(sx_q, wx), y0: min8(sy_q, wy),
                          x1: max8(sx_q, wx), y1: max8(sy_q, wy), colour: wcol};
          end else begin
            err_set = 1'b1;
          end
        end
        ADDR_CLEAR: begin
          fifo_push = 1'b1;
          push_cmd  = '{x0: 8'd0, y0: 8'd0, x1: 8'(H_RES - 1), y1: 8'(V_RES - 1), colour: wcol};
        end
        ADDR_ERR_CLR: err_clr = 1'b1;
        default: ;
      endcase
    end
    // Set wins over a simultaneous clear
    err_d = err_set | (err_q & ~err_clr);
  end

  // Zero-latency STATUS read; everything else reads zero
  always_comb begin
    bus.readdata = '0;
    if (bus.read && (bus.address == ADDR_STATUS)) begin
      bus.readdata[ST_BUSY_BIT]          = busy;
      bus.readdata[ST_FULL_BIT]          = fifo_full;
      bus.readdata[ST_ERR_BIT]           = err_q;
      bus.readdata[ST_COUNT_LSB +: 8]    = 8'(fifo_count);
    end
  end

  // State register for FSM, datapath and control registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cx_q    <= '0;
      cy_q    <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      col_q   <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      col_q   <= col_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      err_q   <= err_d;
    end
  end

  // Rasteriser next state: load a command in IDLE, walk it row-major in DRAW
  always_comb begin
    state_d  = state_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    x0_d     = x0_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    col_d    = col_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cx_d     = fifo_rdata.x0;
          cy_d     = fifo_rdata.y0;
          x0_d     = fifo_rdata.x0;
          x1_d     = fifo_rdata.x1;
          y1_d     = fifo_rdata.y1;
          col_d    = fifo_rdata.colour[COLOUR_W-1:0];
          state_d  = StDraw;
        end
      end
      StDraw: begin
        if (bus.pix_ready) begin
          if (cx_q != x1_q) begin
            cx_d = cx_q + 8'd1;
          end else begin
            cx_d = x0_q;
            if (cy_q != y1_q) cy_d = cy_q + 8'd1;
            else              state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pixel stream outputs, held stable while the sink stalls
  always_comb begin
    bus.pix_plot   = (state_q == StDraw);
    bus.pix_x      = cx_q;
    bus.pix_y      = cy_q;
    bus.pix_colour = col_q;
  end

endmodule

// File: tb/tb_vga_avalon_fill.sv
// Self-checking bench for vga_avalon_fill: register table plus pixel scoreboard.
module tb_vga_avalon_fill;
  import vga_fill_pkg::*;

  localparam int unsigned H_RES      = 160;
  localparam int unsigned V_RES      = 120;
  localparam int unsigned COLOUR_W   = 8;
  localparam int unsigned FIFO_DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vga_avalon_fill_if #(.COLOUR_W(COLOUR_W)) bus ();

  vga_avalon_fill #(
    .H_RES     (H_RES),
    .V_RES     (V_RES),
    .COLOUR_W  (COLOUR_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [7:0]          x;
    logic [7:0]          y;
    logic [COLOUR_W-1:0] c;
  } pix_t;

  typedef enum {OpW, OpR, OpDrain} op_e;
  typedef struct {
    op_e         op;
    logic [3:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
    string       name;
  } vec_t;

  pix_t        sb[$];
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  int unsigned pix_seen = 0;
  pix_t        last_pix;
  logic        prev_stall = 1'b0;
  pix_t        prev_pix;
  logic [7:0]  m_sx = 8'd0;
  logic [7:0]  m_sy = 8'd0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  function automatic logic [31:0] wd(input int x, input int y, input int c);
    return {8'(y), 8'(x), 16'(c)};
  endfunction

  // Reference model: expected pixels of a rectangle in raster order
  function automatic void push_rect(input logic [7:0] ax, input logic [7:0] ay,
                                    input logic [7:0] bx, input logic [7:0] by,
                                    input logic [COLOUR_W-1:0] c);
    int x0, x1, y0, y1;
    x0 = (ax < bx) ? ax : bx;  x1 = (ax < bx) ? bx : ax;
    y0 = (ay < by) ? ay : by;  y1 = (ay < by) ? by : ay;
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) sb.push_back({8'(x), 8'(y), c});
  endfunction

  function automatic void model_write(input logic [3:0] a, input logic [31:0] d);
    logic [7:0] x, y;
    logic [COLOUR_W-1:0] c;
    logic ok;
    x = d[23:16];  y = d[31:24];  c = d[COLOUR_W-1:0];
    ok = (int'(x) < H_RES) && (int'(y) < V_RES);
    case (a)
      4'd0: if (ok) push_rect(x, y, x, y, c);
      4'd1: if (ok) begin m_sx = x; m_sy = y; end
      4'd2: if (ok) push_rect(m_sx, m_sy, x, y, c);
      4'd3: push_rect(8'd0, 8'd0, 8'(H_RES - 1), 8'(V_RES - 1), c);
      default: ;
    endcase
  endfunction

  // Pixel monitor: scoreboard compare on handshake, stability while stalled
  always @(negedge clk) begin
    pix_t cur;
    pix_t exp;
    cur = {bus.pix_x, bus.pix_y, bus.pix_colour};
    if (reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_plot", 32'(bus.pix_plot), 32'd1);
        check("hold_pix", 32'(cur), 32'(prev_pix));
      end
      if (bus.pix_plot && bus.pix_ready) begin
        pix_seen <= pix_seen + 1;
        check("pixel_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp = sb.pop_front();
          check("pixel", 32'(cur), 32'(exp));
        end
        last_pix <= cur;
      end
      prev_stall <= bus.pix_plot && !bus.pix_ready;
      prev_pix   <= cur;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    int n;
    model_write(a, d);
    bus.address   = a;
    bus.writedata = d;
    bus.write     = 1'b1;
    n = 0;
    @(negedge clk);
    while (bus.waitrequest && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("write_accept_bound", 32'(n < 200), 32'd1);
    @(posedge clk);
    #1;
    bus.write = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    bus.address = a;
    bus.read    = 1'b1;
    @(negedge clk);
    d = bus.readdata;
    @(posedge clk);
    #1;
    bus.read = 1'b0;
  endtask

  task automatic drain(input int budget, input bit rnd);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      if (rnd) bus.pix_ready = 1'($urandom_range(0, 1));
      n++;
    end
    check("drain_done", 32'(sb.size()), 32'd0);
    bus.pix_ready = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[17];
    logic [31:0] rd;
    int unsigned seen0;

    bus.address = '0;  bus.read = 1'b0;  bus.write = 1'b0;
    bus.writedata = '0;  bus.pix_ready = 1'b1;
    reset = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    bus.address = ADDR_STATUS;  bus.read = 1'b1;
    #1;
    check("rst_readdata", bus.readdata, 32'd0);
    check("rst_plot", 32'(bus.pix_plot), 32'd0);
    check("rst_waitreq", 32'(bus.waitrequest), 32'd0);
    bus.read = 1'b0;
    reset = 1'b0;
    tick();

    // Single PLOT: first pixel two cycles after accept, exactly one pixel
    bus_write(ADDR_PLOT, wd(5, 7, 8'hAA));
    @(negedge clk);
    check("lat_after_e0", 32'(bus.pix_plot), 32'd0);
    @(negedge clk);
    check("lat_after_e1", 32'(bus.pix_plot), 32'd1);
    check("lat_pix", {8'h0, bus.pix_x, bus.pix_y, bus.pix_colour}, 32'h0005_07AA);
    @(negedge clk);
    check("single_pixel", 32'(bus.pix_plot), 32'd0);
    tick();
    bus_read(ADDR_STATUS, rd);
    check("busy_clear", rd, 32'd0);

    // Register-level table
    tbl[0]  = '{OpW, ADDR_PLOT, wd(10, 20, 8'h33), 0, "plot"};
    tbl[1]  = '{OpDrain, 0, 0, 0, "drain"};
    tbl[2]  = '{OpR, ADDR_STATUS, 0, 32'h0, "st_idle"};
    tbl[3]  = '{OpW, ADDR_PLOT, wd(160, 0, 1), 0, "plot_x_oob"};
    tbl[4]  = '{OpR, ADDR_STATUS, 0, 32'h4, "st_err_plot"};
    tbl[5]  = '{OpW, ADDR_ERR_CLR, 0, 0, "err_clr"};
    tbl[6]  = '{OpR, ADDR_STATUS, 0, 32'h0, "st_err_cleared"};
    tbl[7]  = '{OpW, ADDR_XY0, wd(3, 120, 0), 0, "xy0_y_oob"};
    tbl[8]  = '{OpR, ADDR_STATUS, 0, 32'h4, "st_err_xy0"};
    tbl[9]  = '{OpW, ADDR_ERR_CLR, 0, 0, "err_clr"};
    tbl[10] = '{OpW, ADDR_XY1_GO, wd(0, 200, 7), 0, "xy1_y_oob"};
    tbl[11] = '{OpR, ADDR_STATUS, 0, 32'h4, "st_err_xy1"};
    tbl[12] = '{OpW, ADDR_ERR_CLR, 0, 0, "err_clr"};
    tbl[13] = '{OpW, ADDR_PLOT, wd(159, 119, 8'h5A), 0, "plot_corner"};
    tbl[14] = '{OpDrain, 0, 0, 0, "drain"};
    tbl[15] = '{OpR, ADDR_STATUS, 0, 32'h0, "st_after_corner"};
    tbl[16] = '{OpR, 4'd7, 0, 32'h0, "rd_unmapped"};
    for (int i = 0; i < 17; i++) begin
      case (tbl[i].op)
        OpW:     bus_write(tbl[i].a, tbl[i].d);
        OpR: begin
          bus_read(tbl[i].a, rd);
          check(tbl[i].name, rd, tbl[i].exp);
        end
        default: drain(200, 1'b0);
      endcase
    end
    check("corner_pixel", 32'(last_pix), 32'h009F_775A);

    // Rectangle with swapped corners
    seen0 = pix_seen;
    bus_write(ADDR_XY0, wd(3, 2, 0));
    bus_write(ADDR_XY1_GO, wd(1, 4, 8'h11));
    drain(200, 1'b0);
    check("rect_count", pix_seen - seen0, 32'd9);
    check("rect_last", 32'(last_pix), 32'h0003_0411);

    // Backpressure: one drawing plus a full FIFO, then a stalled write
    seen0 = pix_seen;
    bus.pix_ready = 1'b0;
    for (int i = 0; i < 9; i++) bus_write(ADDR_PLOT, wd(i * 10, i + 1, i + 1));
    bus_read(ADDR_STATUS, rd);
    check("st_full", rd, 32'h0000_0803);
    model_write(ADDR_PLOT, wd(100, 50, 8'h77));
    bus.address = ADDR_PLOT;  bus.writedata = wd(100, 50, 8'h77);  bus.write = 1'b1;
    @(negedge clk);
    check("wait_full", 32'(bus.waitrequest), 32'd1);
    repeat (3) @(negedge clk);
    check("wait_hold", 32'(bus.waitrequest), 32'd1);
    @(posedge clk);
    #1;
    bus.pix_ready = 1'b1;
    tick();
    bus.pix_ready = 1'b0;
    @(negedge clk);
    check("wait_pop_cycle", 32'(bus.waitrequest), 32'd1);
    @(negedge clk);
    check("wait_release", 32'(bus.waitrequest), 32'd0);
    tick();
    bus.write = 1'b0;
    bus.pix_ready = 1'b1;
    drain(400, 1'b0);
    check("bp_count", pix_seen - seen0, 32'd10);

    // Full-screen CLEAR under random backpressure
    seen0 = pix_seen;
    bus_write(ADDR_CLEAR, wd(0, 0, 8'h00));
    drain(70000, 1'b1);
    check("clear_count", pix_seen - seen0, 32'd19200);
    check("clear_last", 32'(last_pix), 32'h009F_7700);

    // Asynchronous reset in the middle of a CLEAR
    bus_write(ADDR_CLEAR, wd(0, 0, 8'h3C));
    repeat (50) tick();
    reset = 1'b1;
    #1;
    check("rst_mid_plot", 32'(bus.pix_plot), 32'd0);
    check("rst_mid_pix", {8'h0, bus.pix_x, bus.pix_y, bus.pix_colour}, 32'd0);
    bus_read(ADDR_STATUS, rd);
    check("rst_mid_status", rd, 32'd0);
    sb.delete();
    m_sx = 8'd0;
    m_sy = 8'd0;
    tick();
    reset = 1'b0;
    seen0 = pix_seen;
    repeat (60) tick();
    check("no_pix_after_rst", pix_seen - seen0, 32'd0);
    bus_read(ADDR_STATUS, rd);
    check("st_after_rst", rd, 32'd0);
    // Staged corner must be back at (0,0)
    seen0 = pix_seen;
    bus_write(ADDR_XY1_GO, wd(1, 1, 8'h42));
    drain(200, 1'b0);
    check("staged_reset_count", pix_seen - seen0, 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
